// File: rtl/complex_axpy_stream.sv
// Streaming complex axpy: result = b +/- (a or conj(a)) * c per lane, in fixed point.
// Three-stage pipeline: input capture, complex product, add/sub with lane masking.
module complex_axpy_stream #(
  parameter int NOE  = 19,
  parameter int NI   = 8,
  parameter int EW   = 32,
  parameter int FRAC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             conj_en,
  input  logic [EW-1:0]    constant,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW*NI-1:0] first_row_input,
  input  logic [EW*NI-1:0] second_row_input,
  output logic             out_valid,
  output logic [EW*NI-1:0] result,
  output logic             busy,
  output logic             finish
);

  localparam int HW     = EW / 2;
  localparam int PW     = 2 * HW + 1;
  localparam int NBEATS = (NOE + NI - 1) / NI;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);
  localparam logic signed [PW-1:0] SMAX = {{(PW-HW+1){1'b0}}, {(HW-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = {{(PW-HW+1){1'b1}}, {(HW-1){1'b0}}};

  function automatic logic [NI-1:0] last_lane_mask();
    logic [NI-1:0] m;
    for (int k = 0; k < NI; k++) m[k] = (((NBEATS - 1) * NI + k) < NOE);
    return m;
  endfunction

  localparam logic [NI-1:0] LAST_MASK = last_lane_mask();

  function automatic logic [HW-1:0] sat(input logic signed [PW-1:0] v);
    if (v > SMAX) return SMAX[HW-1:0];
    if (v < SMIN) return SMIN[HW-1:0];
    return v[HW-1:0];
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic             op_q, conj_q;
  logic [EW-1:0]    c_q;
  logic [CW-1:0]    beat_cnt;
  logic             accept;

  logic             s1_valid, s1_last, s2_valid, s2_last;
  logic [NI-1:0]    s1_mask, s2_mask;
  logic [EW*NI-1:0] s1_a, s1_b, s2_p, s2_b;
  logic [EW*NI-1:0] prod_comb, sum_comb;

  assign in_ready = (state == RUN);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < NI; k++) begin : g_lane
    logic signed [HW-1:0] ar, ai, cr, ci, br, bi, pr, pi;
    logic signed [PW-1:0] arx, aix, crx, cix, mul_r, mul_i;
    logic signed [PW-1:0] brx, bix, prx, pix, add_r, add_i;

    assign ar = s1_a[EW*k+EW-1 -: HW];
    assign ai = s1_a[EW*k+HW-1 -: HW];
    assign cr = c_q[EW-1 -: HW];
    assign ci = c_q[HW-1 -: HW];
    // Widen before negating so conj of the most negative value stays exact.
    assign arx = PW'(ar);
    assign aix = conj_q ? -PW'(ai) : PW'(ai);
    assign crx = PW'(cr);
    assign cix = PW'(ci);
    assign mul_r = arx * crx - aix * cix;
    assign mul_i = arx * cix + aix * crx;
    assign prod_comb[EW*k +: EW] = {sat(mul_r >>> FRAC), sat(mul_i >>> FRAC)};

    assign br  = s2_b[EW*k+EW-1 -: HW];
    assign bi  = s2_b[EW*k+HW-1 -: HW];
    assign pr  = s2_p[EW*k+EW-1 -: HW];
    assign pi  = s2_p[EW*k+HW-1 -: HW];
    assign brx = PW'(br);
    assign bix = PW'(bi);
    assign prx = PW'(pr);
    assign pix = PW'(pi);
    assign add_r = op_q ? brx - prx : brx + prx;
    assign add_i = op_q ? bix - pix : bix + pix;
    assign sum_comb[EW*k +: EW] = s2_mask[k] ? {sat(add_r), sat(add_i)} : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      op_q      <= 1'b0;
      conj_q    <= 1'b0;
      c_q       <= '0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      finish    <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q     <= op;
          conj_q   <= conj_en;
          c_q      <= constant;
          beat_cnt <= '0;
          state    <= RUN;
        end
        RUN: if (accept) begin
          if (beat_cnt == LAST_BEAT) state <= DRAIN;
          else beat_cnt <= beat_cnt + 1'b1;
        end
        DRAIN: if (finish) state <= IDLE;
        default: state <= IDLE;
      endcase

      s1_valid <= accept;
      if (accept) begin
        s1_a    <= first_row_input;
        s1_b    <= second_row_input;
        s1_last <= (beat_cnt == LAST_BEAT);
        s1_mask <= (beat_cnt == LAST_BEAT) ? LAST_MASK : '1;
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_p    <= prod_comb;
        s2_b    <= s1_b;
        s2_last <= s1_last;
        s2_mask <= s1_mask;
      end

      out_valid <= s2_valid;
      finish    <= s2_valid && s2_last;
      if (s2_valid) result <= sum_comb;
    end
  end

endmodule
